keypad_encoder: RTL and testbench

Upstream input stage for the microwave controller: it turns the raw, bouncing one-hot 10-key keypad into clean, single-cycle BCD digit strobes that the controller's time-entry logic shifts into its minute/second registers. It synchronises the keypad and debounces both press and release. It rejects multi-key presses and emits exactly one strobe per physical press. It runs on the controller's 100 Hz (10 ms) system clock.

---
 rtl/mw_pkg.sv | 30 +++
 rtl/keypad_sync.sv | 26 ++
 rtl/keypad_encoder.sv | 168 ++++++++++++++++
 tb/tb_keypad_encoder.sv | 351 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mw_pkg.sv
// Shared microwave-controller definitions: keypad FSM encoding, key/digit widths and BCD limits.
package mw_pkg;

  localparam int unsigned KEY_COUNT = 10;
  localparam int unsigned DIGIT_W   = 4;
  localparam int unsigned STATE_W   = 3;

  // Limits used by the controller's minute/second time registers
  localparam logic [DIGIT_W-1:0] BCD_DIGIT_MAX    = 4'd9;
  localparam logic [DIGIT_W-1:0] BCD_SEC_TENS_MAX = 4'd5;

  typedef enum logic [STATE_W-1:0] {
    KP_IDLE     = 3'd0,
    KP_DEBOUNCE = 3'd1,
    KP_PRESSED  = 3'd2,
    KP_REJECT   = 3'd3,
    KP_RELEASE  = 3'd4
  } kp_state_e;

  // One-hot key vector to BCD digit; bit i encodes as digit i
  function automatic logic [DIGIT_W-1:0] key_to_bcd(input logic [KEY_COUNT-1:0] keys);
    logic [DIGIT_W-1:0] d;
    d = '0;
    for (int unsigned i = 0; i < KEY_COUNT; i++) begin
      if (keys[i]) d = DIGIT_W'(i);
    end
    return d;
  endfunction

endpackage

// File: rtl/keypad_sync.sv
// N-bit two-flop synchroniser with asynchronous active-low clear; also used for startn/stopn/door_closed.
module keypad_sync #(
  parameter int unsigned WIDTH = 1
) (
  input  logic             clk,
  input  logic             clearn,
  input  logic [WIDTH-1:0] async_i,
  output logic [WIDTH-1:0] sync_o
);

  logic [WIDTH-1:0] meta_q;
  logic [WIDTH-1:0] sync_q;

  always_ff @(posedge clk or negedge clearn) begin
    if (!clearn) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= async_i;
      sync_q <= meta_q;
    end
  end

  assign sync_o = sync_q;

endmodule

// File: rtl/keypad_encoder.sv
// Synchronises and debounces the raw 10-key keypad, rejects multi-key presses, one BCD strobe per press.
// Build macro KEYPAD_AUTOREPEAT_EN adds a re-strobe every REPEAT_CYCLES cycles while a key is held.
module keypad_encoder
  import mw_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 3,
  parameter int unsigned REPEAT_CYCLES   = 50
) (
  input  logic                 clk,
  input  logic                 clearn,
  input  logic [KEY_COUNT-1:0] keypad,
  output logic [DIGIT_W-1:0]   digit,
  output logic                 digit_valid,
  output logic                 key_held,
  output logic                 multi_key
);

  localparam int unsigned CNT_W = 4;
  localparam logic [CNT_W-1:0] PRESS_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  // The PRESSED sample that first sees zero is the first release sample
  localparam logic [CNT_W-1:0] REL_LAST   = CNT_W'(DEBOUNCE_CYCLES - 2);

  if (DEBOUNCE_CYCLES < 1 || DEBOUNCE_CYCLES > 15) begin : g_bad_debounce
    $error("keypad_encoder: DEBOUNCE_CYCLES must be 1..15");
  end
  if (REPEAT_CYCLES < 2 || REPEAT_CYCLES > 255) begin : g_bad_repeat
    $error("keypad_encoder: REPEAT_CYCLES must be 2..255");
  end

  logic [KEY_COUNT-1:0] ks;
  logic                 ks_zero;
  logic                 ks_onehot;

  kp_state_e            state_q;
  logic [KEY_COUNT-1:0] cap_q;
  logic [CNT_W-1:0]     cnt_q;
  logic [DIGIT_W-1:0]   digit_q;
  logic                 valid_q;
  logic                 held_q;
  logic                 multi_q;

`ifdef KEYPAD_AUTOREPEAT_EN
  localparam int unsigned REP_W = 8;
  localparam logic [REP_W-1:0] REP_LAST = REP_W'(REPEAT_CYCLES - 1);
  logic [REP_W-1:0]     rep_q;
  logic [KEY_COUNT-1:0] ks_prev_q;
`endif

  keypad_sync #(.WIDTH(KEY_COUNT)) u_sync (
    .clk     (clk),
    .clearn  (clearn),
    .async_i (keypad),
    .sync_o  (ks)
  );

  assign ks_zero   = (ks == '0);
  assign ks_onehot = $onehot(ks);

  // Press/release debounce FSM with registered outputs
  always_ff @(posedge clk or negedge clearn) begin
    if (!clearn) begin
      state_q <= KP_IDLE;
      cap_q   <= '0;
      cnt_q   <= '0;
      digit_q <= '0;
      valid_q <= 1'b0;
      held_q  <= 1'b0;
      multi_q <= 1'b0;
`ifdef KEYPAD_AUTOREPEAT_EN
      rep_q     <= '0;
      ks_prev_q <= '0;
`endif
    end else begin
      valid_q <= 1'b0;
`ifdef KEYPAD_AUTOREPEAT_EN
      ks_prev_q <= ks;
`endif
      case (state_q)
        KP_IDLE: begin
          if (ks_onehot) begin
            cap_q   <= ks;
            cnt_q   <= '0;
            state_q <= KP_DEBOUNCE;
          end else if (!ks_zero) begin
            cnt_q   <= '0;
            multi_q <= 1'b1;
            state_q <= KP_REJECT;
          end
        end

        KP_DEBOUNCE: begin
          if (ks != cap_q) begin
            state_q <= KP_IDLE;
          end else if (cnt_q == PRESS_LAST) begin
            digit_q <= key_to_bcd(cap_q);
            valid_q <= 1'b1;
            held_q  <= 1'b1;
            state_q <= KP_PRESSED;
`ifdef KEYPAD_AUTOREPEAT_EN
            rep_q   <= '0;
`endif
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end

        KP_PRESSED: begin
          if (ks_zero) begin
            cnt_q <= '0;
            if (DEBOUNCE_CYCLES == 1) begin
              held_q  <= 1'b0;
              state_q <= KP_IDLE;
            end else begin
              state_q <= KP_RELEASE;
            end
          end
`ifdef KEYPAD_AUTOREPEAT_EN
          else if (ks != cap_q || ks != ks_prev_q) begin
            rep_q <= '0;
          end else if (rep_q == REP_LAST) begin
            rep_q   <= '0;
            valid_q <= 1'b1;
          end else begin
            rep_q <= rep_q + REP_W'(1);
          end
`endif
        end

        KP_RELEASE: begin
          if (!ks_zero) begin
            state_q <= KP_PRESSED;
`ifdef KEYPAD_AUTOREPEAT_EN
            rep_q   <= '0;
`endif
          end else if (cnt_q == REL_LAST) begin
            held_q  <= 1'b0;
            state_q <= KP_IDLE;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end

        KP_REJECT: begin
          if (!ks_zero) begin
            cnt_q <= '0;
          end else if (cnt_q == PRESS_LAST) begin
            multi_q <= 1'b0;
            state_q <= KP_IDLE;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end

        default: begin
          held_q  <= 1'b0;
          multi_q <= 1'b0;
          state_q <= KP_IDLE;
        end
      endcase
    end
  end

  assign digit       = digit_q;
  assign digit_valid = valid_q;
  assign key_held    = held_q;
  assign multi_key   = multi_q;

endmodule

// File: tb/tb_keypad_encoder.sv
// Self-checking bench for keypad_encoder: directed scenarios plus random keypad traffic vs a reference model.
module tb_keypad_encoder;

  localparam int unsigned DC  = 3;
  localparam int unsigned REP = 50;
`ifdef KEYPAD_AUTOREPEAT_EN
  localparam bit AUTOREP = 1'b1;
`else
  localparam bit AUTOREP = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       clearn;
  logic [9:0] keypad;
  logic [3:0] digit;
  logic       digit_valid;
  logic       key_held;
  logic       multi_key;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model state: key samples as seen after the two-flop delay, plus press/release bookkeeping
  logic [9:0] m_s1, m_ks, m_cand, m_key, m_prev;
  int         m_agree, m_zeros, m_quiet, m_rep;
  bit         m_down, m_jam;
  logic [3:0] exp_digit;
  logic       exp_valid, exp_held, exp_multi;

  always #5 clk = ~clk;

  keypad_encoder #(.DEBOUNCE_CYCLES(DC), .REPEAT_CYCLES(REP)) dut (
    .clk         (clk),
    .clearn      (clearn),
    .keypad      (keypad),
    .digit       (digit),
    .digit_valid (digit_valid),
    .key_held    (key_held),
    .multi_key   (multi_key)
  );

  function automatic logic [3:0] bcd_of(input logic [9:0] v);
    for (int i = 0; i < 10; i++) if (v[i]) return 4'(i);
    return 4'd0;
  endfunction

  task automatic model_reset();
    m_s1 = '0; m_ks = '0; m_cand = '0; m_key = '0; m_prev = '0;
    m_agree = 0; m_zeros = 0; m_quiet = 0; m_rep = 0;
    m_down = 1'b0; m_jam = 1'b0;
    exp_digit = '0; exp_valid = 1'b0; exp_held = 1'b0; exp_multi = 1'b0;
  endtask

  // One clock of the behavioural rules applied to the key sample visible at this edge
  task automatic model_step(input logic [9:0] kp);
    logic [9:0] ks;
    ks = m_ks;
    exp_valid = 1'b0;
    if (m_jam) begin
      if (ks == 0) begin
        m_quiet++;
        if (m_quiet == DC) m_jam = 1'b0;
      end else m_quiet = 0;
    end else if (m_down) begin
      if (ks == 0) begin
        m_zeros++;
        if (m_zeros == DC) m_down = 1'b0;
      end else begin
        m_zeros = 0;
        if (AUTOREP) begin
          if (ks == m_key && ks == m_prev) begin
            m_rep++;
            if (m_rep == REP) begin
              exp_valid = 1'b1;
              m_rep = 0;
            end
          end else m_rep = 0;
        end
      end
    end else if (m_cand != 0) begin
      if (ks == m_cand) begin
        m_agree++;
        if (m_agree == DC) begin
          m_down = 1'b1; m_key = m_cand; m_zeros = 0; m_rep = 0;
          exp_valid = 1'b1; exp_digit = bcd_of(m_cand);
          m_cand = '0;
        end
      end else m_cand = '0;
    end else if (ks != 0) begin
      if ($countones(ks) == 1) begin
        m_cand = ks; m_agree = 0;
      end else begin
        m_jam = 1'b1; m_quiet = 0;
      end
    end
    m_prev = ks;
    m_ks = m_s1;
    m_s1 = kp;
    exp_held = m_down;
    exp_multi = m_jam;
  endtask

  task automatic tick(input logic [9:0] kp);
    keypad = kp;
    @(posedge clk);
    model_step(kp);
    #1;
  endtask

  task automatic test_reset();
    keypad = '0;
    clearn = 1'b0;
    model_reset();
    #12;
    n_cmp++;
    if ({digit, digit_valid, key_held, multi_key} !== 7'h00) begin
      n_bad++;
      $display("FAIL reset_outputs: got %h want 00", {digit, digit_valid, key_held, multi_key});
    end
    @(negedge clk);
    clearn = 1'b1;
  endtask

  task automatic test_single_press();
    int first, cnt;
    first = -1; cnt = 0;
    for (int e = 1; e <= 10; e++) begin
      tick(10'b0000000010);
      n_cmp++;
      if ({digit, digit_valid, key_held, multi_key} !== {exp_digit, exp_valid, exp_held, exp_multi}) begin
        n_bad++;
        $display("FAIL single_model e=%0d: got %h want %h", e, {digit, digit_valid, key_held, multi_key},
                 {exp_digit, exp_valid, exp_held, exp_multi});
      end
      if (digit_valid) begin
        cnt++;
        if (first < 0) first = e;
      end
    end
    n_cmp++;
    if (first != 6) begin n_bad++; $display("FAIL single_latency: got edge %0d want 6", first); end
    n_cmp++;
    if (cnt != 1) begin n_bad++; $display("FAIL single_count: got %0d want 1", cnt); end
    n_cmp++;
    if (digit !== 4'd1) begin n_bad++; $display("FAIL single_digit: got %0d want 1", digit); end
    n_cmp++;
    if (key_held !== 1'b1) begin n_bad++; $display("FAIL single_held: got %b want 1", key_held); end
  endtask

  task automatic test_bounce_press();
    int first, cnt;
    first = -1; cnt = 0;
    for (int i = 0; i < 12; i++) tick('0);
    for (int i = 0; i < 15; i++) begin
      tick((i < 5) ? ((i % 2 == 1) ? 10'b0010000000 : 10'b0) : 10'b0010000000);
      n_cmp++;
      if ({digit, digit_valid, key_held, multi_key} !== {exp_digit, exp_valid, exp_held, exp_multi}) begin
        n_bad++;
        $display("FAIL bounce_model i=%0d: got %h want %h", i, {digit, digit_valid, key_held, multi_key},
                 {exp_digit, exp_valid, exp_held, exp_multi});
      end
      if (digit_valid) begin
        cnt++;
        if (first < 0) first = i - 4;
      end
    end
    n_cmp++;
    if (first != DC + 3) begin n_bad++; $display("FAIL bounce_latency: got edge %0d want %0d", first, DC + 3); end
    n_cmp++;
    if (cnt != 1 || digit !== 4'd7) begin
      n_bad++; $display("FAIL bounce_strobe: got count %0d digit %0d want 1 / 7", cnt, digit);
    end
  endtask

  task automatic test_multi_key();
    int cnt;
    cnt = 0;
    for (int i = 0; i < 12; i++) tick('0);
    for (int i = 0; i < 34; i++) begin
      tick((i < 6) ? 10'b0010000001 : (i < 14) ? 10'b0 : 10'b0000000001);
      n_cmp++;
      if ({digit, digit_valid, key_held, multi_key} !== {exp_digit, exp_valid, exp_held, exp_multi}) begin
        n_bad++;
        $display("FAIL multi_model i=%0d: got %h want %h", i, {digit, digit_valid, key_held, multi_key},
                 {exp_digit, exp_valid, exp_held, exp_multi});
      end
      if (digit_valid) cnt++;
      if (i == 5) begin
        n_cmp++;
        if (multi_key !== 1'b1 || cnt != 0) begin
          n_bad++; $display("FAIL multi_reject: got multi %b strobes %0d want 1 / 0", multi_key, cnt);
        end
      end
      if (i == 13) begin
        n_cmp++;
        if (multi_key !== 1'b0) begin n_bad++; $display("FAIL multi_clear: got %b want 0", multi_key); end
      end
    end
    n_cmp++;
    if (cnt != 1 || digit !== 4'd0) begin
      n_bad++; $display("FAIL multi_then_single: got count %0d digit %0d want 1 / 0", cnt, digit);
    end
  endtask

  task automatic test_release_bounce();
    int cnt, fall;
    cnt = 0; fall = -1;
    for (int i = 0; i < 12; i++) tick('0);
    for (int i = 0; i < 30; i++) begin
      if (i < 8) tick(10'b0000000100);
      else if (i < 20) tick((i % 2 == 0) ? 10'b0 : 10'b0000000100);
      else tick('0);
      n_cmp++;
      if ({digit, digit_valid, key_held, multi_key} !== {exp_digit, exp_valid, exp_held, exp_multi}) begin
        n_bad++;
        $display("FAIL release_model i=%0d: got %h want %h", i, {digit, digit_valid, key_held, multi_key},
                 {exp_digit, exp_valid, exp_held, exp_multi});
      end
      if (digit_valid) cnt++;
      if (i >= 20 && !key_held && fall < 0) fall = i - 19;
    end
    n_cmp++;
    if (cnt != 1 || digit !== 4'd2) begin
      n_bad++; $display("FAIL release_strobe: got count %0d digit %0d want 1 / 2", cnt, digit);
    end
    n_cmp++;
    if (fall != DC + 2) begin n_bad++; $display("FAIL release_fall: got edge %0d want %0d", fall, DC + 2); end
  endtask

  task automatic test_reset_mid_press();
    int first, cnt;
    first = -1; cnt = 0;
    for (int i = 0; i < 12; i++) tick('0);
    for (int i = 0; i < 4; i++) tick(10'b1000000000);
    clearn = 1'b0;
    model_reset();
    #2;
    n_cmp++;
    if ({digit, digit_valid, key_held, multi_key} !== 7'h00) begin
      n_bad++;
      $display("FAIL midreset_outputs: got %h want 00", {digit, digit_valid, key_held, multi_key});
    end
    @(negedge clk);
    clearn = 1'b1;
    for (int e = 1; e <= 10; e++) begin
      tick(10'b1000000000);
      n_cmp++;
      if ({digit, digit_valid, key_held, multi_key} !== {exp_digit, exp_valid, exp_held, exp_multi}) begin
        n_bad++;
        $display("FAIL midreset_model e=%0d: got %h want %h", e, {digit, digit_valid, key_held, multi_key},
                 {exp_digit, exp_valid, exp_held, exp_multi});
      end
      if (digit_valid) begin
        cnt++;
        if (first < 0) first = e;
      end
    end
    n_cmp++;
    if (first != 6 || cnt != 1 || digit !== 4'd9) begin
      n_bad++;
      $display("FAIL midreset_strobe: got edge %0d count %0d digit %0d want 6 / 1 / 9", first, cnt, digit);
    end
  endtask

  task automatic test_autorepeat();
    int got[$];
    int want[$];
    want = AUTOREP ? '{6, 56, 106} : '{6};
    for (int i = 0; i < 12; i++) tick('0);
    for (int e = 1; e <= 120; e++) begin
      tick(10'b0000100000);
      n_cmp++;
      if ({digit, digit_valid, key_held, multi_key} !== {exp_digit, exp_valid, exp_held, exp_multi}) begin
        n_bad++;
        $display("FAIL repeat_model e=%0d: got %h want %h", e, {digit, digit_valid, key_held, multi_key},
                 {exp_digit, exp_valid, exp_held, exp_multi});
      end
      if (digit_valid) begin
        got.push_back(e);
        n_cmp++;
        if (digit !== 4'd5) begin n_bad++; $display("FAIL repeat_digit: got %0d want 5", digit); end
      end
    end
    n_cmp++;
    if (got.size() != want.size()) begin
      n_bad++; $display("FAIL repeat_count: got %0d want %0d", got.size(), want.size());
    end else begin
      foreach (want[k]) begin
        n_cmp++;
        if (got[k] != want[k]) begin
          n_bad++; $display("FAIL repeat_edge%0d: got %0d want %0d", k, got[k], want[k]);
        end
      end
    end
  endtask

  task automatic test_random();
    int kind, len;
    logic [9:0] key, kp;
    for (int s = 0; s < 70; s++) begin
      if (s == 35) begin
        clearn = 1'b0;
        model_reset();
        #2;
        n_cmp++;
        if ({digit, digit_valid, key_held, multi_key} !== 7'h00) begin
          n_bad++;
          $display("FAIL random_reset: got %h want 00", {digit, digit_valid, key_held, multi_key});
        end
        @(negedge clk);
        clearn = 1'b1;
      end
      kind = $urandom_range(0, 4);
      key = 10'b1 << $urandom_range(0, 9);
      len = (kind == 0) ? $urandom_range(4, 25) : (kind == 1) ? $urandom_range(1, 12) : $urandom_range(1, 8);
      for (int c = 0; c < len; c++) begin
        case (kind)
          0: kp = key;
          1: kp = '0;
          2: kp = ($urandom_range(0, 2) == 0) ? 10'($urandom) : (($urandom_range(0, 1) == 0) ? key : 10'b0);
          3: kp = key | (10'b1 << $urandom_range(0, 9));
          default: kp = (c < 2) ? key : 10'b0;
        endcase
        tick(kp);
        n_cmp++;
        if ({digit, digit_valid, key_held, multi_key} !== {exp_digit, exp_valid, exp_held, exp_multi}) begin
          n_bad++;
          $display("FAIL random_model s=%0d c=%0d kp=%b: got %h want %h", s, c, kp,
                   {digit, digit_valid, key_held, multi_key}, {exp_digit, exp_valid, exp_held, exp_multi});
        end
      end
    end
  endtask

  initial begin
    clearn = 1'b0;
    keypad = '0;
    model_reset();
    test_reset();
    test_single_press();
    test_bounce_press();
    test_multi_key();
    test_release_bounce();
    test_reset_mid_press();
    test_autorepeat();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
